// File: rtl/l2_write_buffer_if.sv
// L2 <-> write-buffer <-> physical-memory signal bundle.
// The slave view belongs to the buffer; the master view belongs to whatever drives the L2 and memory sides.
interface l2_write_buffer_if #(
    parameter int s_line = 256
);
    logic [31:0]       mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [s_line-1:0] mem_wdata;
    logic [s_line-1:0] mem_rdata;
    logic              mem_resp;

    logic [31:0]       pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [s_line-1:0] pmem_wdata;
    logic [s_line-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_wdata, pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_wdata, pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/l2_write_buffer.sv
// Write-back buffer between the L2 and physical memory: absorbs evictions, forwards
// buffered lines on read hits, and drains oldest-first when the L2 side is quiet.
module l2_write_buffer #(
    parameter int depth    = 4,
    parameter int s_offset = 5,
    parameter int s_line   = 256
) (
    input logic           clk,
    input logic           rst,
    l2_write_buffer_if.slave bus
);
    localparam int tag_w = 32 - s_offset;
    localparam int ptr_w = $clog2(depth);

    typedef logic [tag_w-1:0] tag_t;
    typedef logic [ptr_w-1:0] ptr_t;
    typedef logic [ptr_w:0]   cnt_t;
    typedef enum logic [1:0] {IDLE, RESP, RD_MEM, DRAIN} state_t;

    state_t            state, state_d;
    logic [depth-1:0]  valid;
    tag_t              tags [depth];
    logic [s_line-1:0] data [depth];
    ptr_t              head, tail;
    cnt_t              count;

    tag_t req_tag;
    logic hit;
    ptr_t hit_idx;
    logic do_wr_hit, do_wr_alloc, do_rd_hit, do_rd_miss, do_drain, drain_done, rd_done;
    logic unused_low;

    assign req_tag    = bus.mem_address[31:s_offset];
    assign unused_low = ^bus.mem_address[s_offset-1:0];

    // Tags are unique among valid entries, so at most one match fires.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < depth; i++) begin
            if (valid[i] && tags[i] == req_tag) begin
                hit     = 1'b1;
                hit_idx = ptr_t'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d     = state;
        do_wr_hit   = 1'b0;
        do_wr_alloc = 1'b0;
        do_rd_hit   = 1'b0;
        do_rd_miss  = 1'b0;
        do_drain    = 1'b0;
        drain_done  = 1'b0;
        rd_done     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_write && hit) begin
                    do_wr_hit = 1'b1;
                    state_d   = RESP;
                end else if (bus.mem_write && count != cnt_t'(depth)) begin
                    do_wr_alloc = 1'b1;
                    state_d     = RESP;
                end else if (bus.mem_read && hit) begin
                    do_rd_hit = 1'b1;
                    state_d   = RESP;
                end else if (bus.mem_read) begin
                    do_rd_miss = 1'b1;
                    state_d    = RD_MEM;
                end else if (count != '0) begin
                    do_drain = 1'b1;
                    state_d  = DRAIN;
                end
            end
            RESP: state_d = IDLE;
            RD_MEM: begin
                if (bus.pmem_resp) begin
                    rd_done = 1'b1;
                    state_d = RESP;
                end
            end
            DRAIN: begin
                if (bus.pmem_resp) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered straight from the next state, so each is high exactly while in its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid            <= '0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            bus.mem_resp     <= 1'b0;
            bus.pmem_read    <= 1'b0;
            bus.pmem_write   <= 1'b0;
            bus.mem_rdata    <= '0;
            bus.pmem_address <= '0;
            bus.pmem_wdata   <= '0;
        end else begin
            bus.mem_resp   <= (state_d == RESP);
            bus.pmem_read  <= (state_d == RD_MEM);
            bus.pmem_write <= (state_d == DRAIN);
            if (do_wr_alloc) begin
                valid[tail] <= 1'b1;
                tail        <= tail + ptr_t'(1);
                count       <= count + cnt_t'(1);
            end
            if (drain_done) begin
                valid[head] <= 1'b0;
                head        <= head + ptr_t'(1);
                count       <= count - cnt_t'(1);
            end
            if (do_rd_hit) bus.mem_rdata <= data[hit_idx];
            if (rd_done)   bus.mem_rdata <= bus.pmem_rdata;
            if (do_rd_miss) bus.pmem_address <= {req_tag, {s_offset{1'b0}}};
            if (do_drain) begin
                bus.pmem_address <= {tags[head], {s_offset{1'b0}}};
                bus.pmem_wdata   <= data[head];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr_alloc) tags[tail] <= req_tag;
        if (do_wr_alloc) data[tail] <= bus.mem_wdata;
        if (do_wr_hit)   data[hit_idx] <= bus.mem_wdata;
    end
endmodule

// File: doc/l2_write_buffer.md
Name: l2_write_buffer

Overview:
Write-back buffer sitting between the L2 cache's physical-memory port and the physical memory / burst adapter. It absorbs dirty-line evictions so the L2 sees a 1-cycle write acknowledge, and forwards buffered lines on read hits. It drains entries to memory in the background, oldest first. Read misses take priority over draining.

Parameters:
depth, 4, number of 256-bit line entries (power of two, >=2)
s_offset, 5, line offset bits; addresses are line-aligned
s_line, 256, line width in bits

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
mem_address  in  32  line address from L2 (low s_offset bits ignored)
mem_read  in  1  L2 line read request, held until mem_resp
mem_write  in  1  L2 line write (eviction), held until mem_resp
mem_wdata  in  256  eviction data
mem_rdata  out  256  read data, valid while mem_resp=1
mem_resp  out  1  one-cycle completion pulse
pmem_address  out  32  memory address, low s_offset bits forced 0
pmem_read  out  1  memory read, held until pmem_resp
pmem_write  out  1  memory write, held until pmem_resp
pmem_wdata  out  256  write data
pmem_rdata  in  256  memory read data, valid with pmem_resp
pmem_resp  in  1  memory completion pulse

Behaviour:
- Storage: depth entries {valid, tag=addr[31:s_offset], data}; FIFO head/tail pointers plus count, wrap mod depth. A tag is present in at most one valid entry.
- Reset (async): all valid=0, count=0, pointers=0, state=IDLE; mem_resp, pmem_read, pmem_write=0; mem_rdata, pmem_address, pmem_wdata=0. Reset mid-transaction drops all buffered lines and the outstanding pmem op.
- FSM states: IDLE, RESP, RD_MEM, DRAIN.
- IDLE, priority order:
  1. mem_write, tag hits entry: overwrite that entry's data in place (FIFO position unchanged) -> RESP.
  2. mem_write, miss, count<depth: write at tail, tail++, count++ -> RESP.
  3. mem_read, tag hits: latch entry data into mem_rdata -> RESP.
  4. mem_read, miss: assert pmem_read, pmem_address={tag,0} -> RD_MEM.
  5. count>0 (includes mem_write miss with buffer full): assert pmem_write with head entry -> DRAIN.
  6. Otherwise stay.
- RESP: mem_resp=1 for exactly this cycle -> IDLE. No request is sampled in RESP. Hit latency: request seen at cycle t, mem_resp at t+1.
- RD_MEM: hold pmem_read/address until pmem_resp. On pmem_resp, latch pmem_rdata into mem_rdata, drop pmem_read -> RESP. Miss latency = memory latency + 1. Read-miss data is not allocated in the buffer.
- DRAIN: hold pmem_write/address/wdata (head entry) until pmem_resp. On pmem_resp: clear head valid, head++, count-- -> IDLE. Requests arriving during DRAIN wait; they are sampled in IDLE next cycle.
- Drain is non-preemptible. An in-progress drain of tag X followed by a write of X re-allocates X as a new entry after completion. No hazard exists, because the head has already been popped.
- A full buffer with a pending write costs exactly one drain before the write is accepted.
- pmem_read and pmem_write are never both high. mem_resp is never high outside RESP.
- Simultaneous mem_read and mem_write is illegal from L2 and is not checked; write wins per priority.

Test Plan:
- Write 0x1000_0020 data A -> mem_resp at t+1. In the following idle cycles, pmem_write addr 0x1000_0020 data A; after pmem_resp, count=0.
- Hold memory off (no pmem_resp). Write 4 distinct lines, then a 5th -> first 4 ack at 1-cycle latency. 5th acks only after one drain of the oldest line, then sits at the tail.
- Write X=A, then write X=B while buffered -> single entry, count=1, later drain writes B once.
- Write X=A, then read X before drain -> mem_rdata=A at t+1, no pmem_read issued.
- Read miss Y with buffer non-empty; memory returns C after 5 cycles -> pmem_read precedes the pending drain; mem_rdata=C, mem_resp one cycle after pmem_resp.
- Assert rst mid-DRAIN -> pmem_write drops immediately (async), count=0, a subsequent read of the lost line goes to pmem.
